lcd_init_seq: RTL and testbench
===============================

Name: lcd_init_seq

Overview:
- Table-driven LCD bring-up sequencer for the SPI_LCD design.
- Sequence: pulses the LCD hardware reset, waits the power-up time, then walks an external command table.
- Each table entry issues one command/data byte to the SPI master, inserts a millisecond delay, or ends the sequence.
- Millisecond timing comes from a one-cycle 1 kHz tick-enable pulse generated from the system clock; the block uses no derived clocks.

Parameters:
- TABLE_AW, 5, command table address width (32 entries).
- RESET_MS, 10, lcd_rst_n low time in 1 kHz ticks (legal 1..255).
- POWERUP_MS, 40, wait after lcd_rst_n release, in ticks (legal 1..255).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- tick_1khz  in  1  one-clk-wide pulse, once per ms.
- go  in  1  start-sequence pulse.
- cmd_addr  out  TABLE_AW  table address (registered).
- cmd_word  in  10  table entry {op[1:0], arg[7:0]}; valid one clk after cmd_addr changes.
- spi_start  out  1  one-clk pulse requesting a byte transfer.
- spi_data  out  8  byte to send; held stable from spi_start until spi_busy falls.
- spi_dc  out  1  0 = command, 1 = data; held with spi_data.
- spi_busy  in  1  SPI master transfer in progress.
- lcd_rst_n  out  1  LCD hardware reset, active low.
- seq_busy  out  1  high from accepted go until DONE.
- seq_done  out  1  level; high after END, cleared by the next accepted go.
- seq_err  out  1  watchdog error (optional feature only; otherwise tied 0).

Behaviour:
- Async reset: state IDLE; cmd_addr=0, spi_start=0, spi_data=0, spi_dc=0, lcd_rst_n=1, seq_busy=0, seq_done=0, seq_err=0, delay counter=0.
- Opcodes:
  - 00 = CMD: send arg with dc=0.
  - 01 = DATA: send arg with dc=1.
  - 10 = DELAY: wait arg ticks.
  - 11 = END.
- State machine:
  - IDLE: go=1 -> RST_LOW; clear seq_done and seq_err, set seq_busy, set lcd_rst_n=0, load counter=RESET_MS, set cmd_addr=0.
  - RST_LOW: decrement counter on each tick_1khz. At 0 -> RST_WAIT; set lcd_rst_n=1, load counter=POWERUP_MS.
  - RST_WAIT: decrement on each tick. At 0 -> FETCH.
  - FETCH: one wait cycle for table latency -> DECODE.
  - DECODE, by op:
    - CMD/DATA: latch arg into spi_data and op[0] into spi_dc -> SEND.
    - DELAY with arg=0: advance -> FETCH.
    - DELAY with arg>0: counter=arg -> DELAY.
    - END: -> DONE.
  - SEND: when spi_busy=0, pulse spi_start for exactly 1 clk -> ACK. While spi_busy=1, hold in SEND.
  - ACK: wait for spi_busy=1 -> XFER.
  - XFER: wait for spi_busy=0, then advance -> FETCH.
  - DELAY: decrement on each tick. At 0, advance -> FETCH.
  - DONE: seq_busy=0, seq_done=1 -> IDLE (seq_done holds).
- "Advance" means cmd_addr+1. If cmd_addr is already 2^TABLE_AW-1, go to DONE instead; the address never wraps.
- Tick timing:
  - A delay of N waits exactly N tick_1khz pulses. The first period may be partial, so elapsed time is between N-1 and N ms.
  - A tick coincident with the state entry cycle is not counted.
- go while seq_busy=1 is ignored.
- go in the same cycle as the DONE->IDLE transition is ignored. It is accepted only in IDLE.
- rst mid-sequence aborts immediately to reset values, including lcd_rst_n=1. An SPI transfer already started completes on its own; its result is ignored.
- Exactly one spi_start per CMD/DATA entry. No spi_start outside SEND.

Optional Feature:
- Macro: LCD_SEQ_WATCHDOG_EN.
- With the macro defined: an 8-bit watchdog counts tick_1khz pulses while in SEND, ACK or XFER, and resets on each state entry.
  - If it reaches 255, set seq_err=1 and go to DONE, so seq_done=1 as well.
  - seq_err holds until the next accepted go or rst.
- Without the macro: no watchdog; seq_err is constant 0, and the block can wait on spi_busy indefinitely.

Test Plan:
1. Basic sequence: RESET_MS=2, POWERUP_MS=3, table {CMD 0x11, DATA 0xA5, END}, go pulse -> lcd_rst_n low for 2 ticks, then high; after 3 more ticks, spi_start with data=0x11/dc=0, then data=0xA5/dc=1; seq_done=1, seq_busy=0; exactly 2 spi_start pulses.
2. Delays: table {CMD 0x01, DELAY 5, DELAY 0, CMD 0x29, END} -> second spi_start occurs after exactly 5 ticks following the end of the first transfer; DELAY 0 adds only fetch cycles.
3. Busy handshake: hold spi_busy=1 for 20 clk when entering SEND -> spi_start is withheld until busy falls. After start, the model raises busy 3 clk later -> next fetch only after busy falls.
4. Table overrun: 32-entry table with no END, all CMD -> 32 transfers, then DONE; cmd_addr stops at 31.
5. Reset and go edges: rst asserted during the 2nd transfer's XFER -> all outputs return to reset values asynchronously, including lcd_rst_n=1; go during seq_busy -> ignored; a fresh go afterwards restarts from cmd_addr=0.
6. Watchdog (LCD_SEQ_WATCHDOG_EN defined): spi_busy never falls after start -> seq_err=1 and seq_done=1 after 255 ticks. With the macro undefined, the same stimulus leaves seq_busy=1 and seq_err=0.

Source files
------------

// File: rtl/lcd_init_seq_if.sv
// Sequencer-side bundle: command table port plus SPI master handshake.
// master = sequencer, slave = table ROM / SPI master side.
interface lcd_init_seq_if #(
   parameter int TABLE_AW = 5
);
   logic [TABLE_AW-1:0] cmd_addr;
   logic [9:0]          cmd_word;
   logic                spi_start;
   logic [7:0]          spi_data;
   logic                spi_dc;
   logic                spi_busy;

   modport master (
      output cmd_addr,
      output spi_start,
      output spi_data,
      output spi_dc,
      input  cmd_word,
      input  spi_busy
   );

   modport slave (
      input  cmd_addr,
      input  spi_start,
      input  spi_data,
      input  spi_dc,
      output cmd_word,
      output spi_busy
   );
endinterface

// File: rtl/lcd_init_seq.sv
// LCD bring-up sequencer: reset pulse, power-up wait, then walks a command table.
// Define LCD_SEQ_WATCHDOG_EN to abort stuck SPI transfers after 255 ms via seq_err.
module lcd_init_seq #(
   parameter int TABLE_AW   = 5,
   parameter int RESET_MS   = 10,
   parameter int POWERUP_MS = 40
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           i_tick_1khz,
   input  logic           i_go,
   lcd_init_seq_if.master bus,
   output logic           o_lcd_rst_n,
   output logic           o_seq_busy,
   output logic           o_seq_done,
   output logic           o_seq_err
);

   typedef enum logic [3:0] {
      S_IDLE,
      S_RST_LOW,
      S_RST_WAIT,
      S_FETCH,
      S_DECODE,
      S_SEND,
      S_ACK,
      S_XFER,
      S_DELAY,
      S_DONE
   } state_t;

   localparam logic [1:0] OP_CMD   = 2'b00;
   localparam logic [1:0] OP_DATA  = 2'b01;
   localparam logic [1:0] OP_DELAY = 2'b10;
   localparam logic [1:0] OP_END   = 2'b11;

   localparam logic [7:0] RESET_CNT = 8'(RESET_MS);
   localparam logic [7:0] PWRUP_CNT = 8'(POWERUP_MS);

   localparam logic [TABLE_AW-1:0] ADDR_LAST = '1;
   localparam logic [TABLE_AW-1:0] ADDR_ONE  = TABLE_AW'(1);

   state_t              r_state;
   state_t              w_state;
   logic [TABLE_AW-1:0] r_addr;
   logic [TABLE_AW-1:0] w_addr;
   logic                r_start;
   logic                w_start;
   logic [7:0]          r_data;
   logic [7:0]          w_data;
   logic                r_dc;
   logic                w_dc;
   logic                r_rst_n;
   logic                w_rst_n;
   logic                r_busy;
   logic                w_busy;
   logic                r_done;
   logic                w_done;
   logic [7:0]          r_cnt;
   logic [7:0]          w_cnt;
   logic                w_advance;
   logic [1:0]          w_op;
   logic [7:0]          w_arg;

`ifdef LCD_SEQ_WATCHDOG_EN
   localparam logic [7:0] WDOG_TRIP = 8'd254;

   logic       r_err;
   logic       w_err;
   logic [7:0] r_wdog;
   logic [7:0] w_wdog;
   logic       w_wd_on;
`endif

   assign w_op  = bus.cmd_word[9:8];
   assign w_arg = bus.cmd_word[7:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_addr  <= '0;
         r_start <= 1'b0;
         r_data  <= 8'd0;
         r_dc    <= 1'b0;
         r_rst_n <= 1'b1;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_cnt   <= 8'd0;
`ifdef LCD_SEQ_WATCHDOG_EN
         r_err   <= 1'b0;
         r_wdog  <= 8'd0;
`endif
      end else begin
         r_state <= w_state;
         r_addr  <= w_addr;
         r_start <= w_start;
         r_data  <= w_data;
         r_dc    <= w_dc;
         r_rst_n <= w_rst_n;
         r_busy  <= w_busy;
         r_done  <= w_done;
         r_cnt   <= w_cnt;
`ifdef LCD_SEQ_WATCHDOG_EN
         r_err   <= w_err;
         r_wdog  <= w_wdog;
`endif
      end
   end

   always_comb begin
      w_state   = r_state;
      w_addr    = r_addr;
      w_start   = 1'b0;
      w_data    = r_data;
      w_dc      = r_dc;
      w_rst_n   = r_rst_n;
      w_busy    = r_busy;
      w_done    = r_done;
      w_cnt     = r_cnt;
      w_advance = 1'b0;
`ifdef LCD_SEQ_WATCHDOG_EN
      w_err     = r_err;
      w_wdog    = r_wdog;
      w_wd_on   = 1'b0;
`endif

      unique case (r_state)
         S_IDLE: begin
            if (i_go) begin
               w_state = S_RST_LOW;
               w_done  = 1'b0;
               w_busy  = 1'b1;
               w_rst_n = 1'b0;
               w_cnt   = RESET_CNT;
               w_addr  = '0;
`ifdef LCD_SEQ_WATCHDOG_EN
               w_err   = 1'b0;
`endif
            end
         end
         // Counters expire on the tick that would take them to zero.
         S_RST_LOW: begin
            if (i_tick_1khz) begin
               if (r_cnt <= 8'd1) begin
                  w_state = S_RST_WAIT;
                  w_rst_n = 1'b1;
                  w_cnt   = PWRUP_CNT;
               end else begin
                  w_cnt = r_cnt - 8'd1;
               end
            end
         end
         S_RST_WAIT: begin
            if (i_tick_1khz) begin
               if (r_cnt <= 8'd1) begin
                  w_state = S_FETCH;
                  w_cnt   = 8'd0;
               end else begin
                  w_cnt = r_cnt - 8'd1;
               end
            end
         end
         S_FETCH: begin
            w_state = S_DECODE;
         end
         S_DECODE: begin
            unique case (w_op)
               OP_CMD, OP_DATA: begin
                  w_data  = w_arg;
                  w_dc    = w_op[0];
                  w_state = S_SEND;
               end
               OP_DELAY: begin
                  if (w_arg == 8'd0) begin
                     w_advance = 1'b1;
                  end else begin
                     w_cnt   = w_arg;
                     w_state = S_DELAY;
                  end
               end
               OP_END: begin
                  w_state = S_DONE;
               end
            endcase
         end
         S_SEND: begin
            if (!bus.spi_busy) begin
               w_start = 1'b1;
               w_state = S_ACK;
            end
         end
         S_ACK: begin
            if (bus.spi_busy) begin
               w_state = S_XFER;
            end
         end
         S_XFER: begin
            if (!bus.spi_busy) begin
               w_advance = 1'b1;
            end
         end
         S_DELAY: begin
            if (i_tick_1khz) begin
               if (r_cnt <= 8'd1) begin
                  w_cnt     = 8'd0;
                  w_advance = 1'b1;
               end else begin
                  w_cnt = r_cnt - 8'd1;
               end
            end
         end
         S_DONE: begin
            w_busy  = 1'b0;
            w_done  = 1'b1;
            w_state = S_IDLE;
         end
         default: begin
            w_state = S_IDLE;
         end
      endcase

      // The table address saturates: running off the end finishes the sequence.
      if (w_advance) begin
         if (r_addr == ADDR_LAST) begin
            w_state = S_DONE;
         end else begin
            w_addr  = r_addr + ADDR_ONE;
            w_state = S_FETCH;
         end
      end

`ifdef LCD_SEQ_WATCHDOG_EN
      w_wd_on = (r_state == S_SEND) ||
                (r_state == S_ACK)  ||
                (r_state == S_XFER);
      if (w_wd_on && i_tick_1khz && (r_wdog == WDOG_TRIP)) begin
         w_err   = 1'b1;
         w_start = 1'b0;
         w_state = S_DONE;
      end
      if (w_state != r_state) begin
         w_wdog = 8'd0;
      end else if (w_wd_on && i_tick_1khz) begin
         w_wdog = r_wdog + 8'd1;
      end
`endif
   end

   assign bus.cmd_addr  = r_addr;
   assign bus.spi_start = r_start;
   assign bus.spi_data  = r_data;
   assign bus.spi_dc    = r_dc;
   assign o_lcd_rst_n   = r_rst_n;
   assign o_seq_busy    = r_busy;
   assign o_seq_done    = r_done;

`ifdef LCD_SEQ_WATCHDOG_EN
   assign o_seq_err = r_err;
`else
   assign o_seq_err = 1'b0;
`endif

endmodule

// File: tb/tb_lcd_init_seq.sv
// Directed bench for lcd_init_seq: table ROM + SPI master model, vector table
// plus hand-written timing, handshake, reset and watchdog sequences.
module tb_lcd_init_seq;
   localparam int AW   = 5;
   localparam int TPER = 8;
   localparam int WPER = 4;

   localparam logic [1:0] OP_CMD   = 2'b00;
   localparam logic [1:0] OP_DATA  = 2'b01;
   localparam logic [1:0] OP_DELAY = 2'b10;
   localparam logic [1:0] OP_END   = 2'b11;

   typedef struct {
      int            prog;
      int            exp_n;
      logic [8:0]    exp_first;
      logic [8:0]    exp_last;
      logic [AW-1:0] exp_addr;
   } vec_t;

   logic clk        = 1'b0;
   logic rst        = 1'b1;
   logic go         = 1'b0;
   logic tick_m     = 1'b0;
   logic tick_a     = 1'b0;
   logic tick_auto  = 1'b0;
   logic force_busy = 1'b0;
   logic m_busy     = 1'b0;
   logic m_hang     = 1'b0;
   logic stab_bad   = 1'b0;
   logic tick;
   logic lcd_rst_n;
   logic seq_busy;
   logic seq_done;
   logic seq_err;

   int         checks  = 0;
   int         fails   = 0;
   int         n_start = 0;
   int         tick_cnt = 0;
   int         m_rise  = 0;
   int         m_len   = 0;
   int         tdiv    = 0;
   logic [8:0] cur     = 9'd0;
   logic [8:0] slog[$];
   logic [8:0] expq[$];
   logic [9:0] mem[32];
   vec_t       vecs[5];

   lcd_init_seq_if #(.TABLE_AW(AW)) bus ();

   lcd_init_seq #(
      .TABLE_AW  (AW),
      .RESET_MS  (2),
      .POWERUP_MS(3)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .i_tick_1khz(tick),
      .i_go       (go),
      .bus        (bus),
      .o_lcd_rst_n(lcd_rst_n),
      .o_seq_busy (seq_busy),
      .o_seq_done (seq_done),
      .o_seq_err  (seq_err)
   );

   always #5 clk = ~clk;

   assign tick         = tick_a | tick_m;
   assign bus.spi_busy = m_busy | force_busy;

   always @(posedge clk) bus.cmd_word <= mem[bus.cmd_addr];

   always @(posedge clk) begin
      if (tick_auto) begin
         tdiv   <= (tdiv == TPER - 1) ? 0 : tdiv + 1;
         tick_a <= (tdiv == TPER - 1);
      end else begin
         tdiv   <= 0;
         tick_a <= 1'b0;
      end
   end

   // SPI master model: busy rises 3 clk after start, lasts 4 clk unless hung.
   always @(posedge clk) begin
      if (tick) tick_cnt <= tick_cnt + 1;
      if (bus.spi_start) begin
         n_start <= n_start + 1;
         slog.push_back({bus.spi_dc, bus.spi_data});
         cur    <= {bus.spi_dc, bus.spi_data};
         m_rise <= 3;
      end else if (m_rise != 0) begin
         m_rise <= m_rise - 1;
         if (m_rise == 1) begin
            m_busy <= 1'b1;
            m_len  <= 4;
         end
      end else if (m_busy && !m_hang) begin
         m_len <= m_len - 1;
         if (m_len <= 1) m_busy <= 1'b0;
      end
      if (m_busy && seq_busy && ({bus.spi_dc, bus.spi_data} != cur))
         stab_bad <= 1'b1;
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic load_prog(input int p);
      for (int i = 0; i < 32; i++) mem[i] = {OP_END, 8'h00};
      case (p)
         0: begin
            mem[0] = {OP_CMD, 8'h11};
            mem[1] = {OP_DATA, 8'hA5};
         end
         1: begin
            mem[0] = {OP_CMD, 8'h01};
            mem[1] = {OP_DELAY, 8'd5};
            mem[2] = {OP_DELAY, 8'd0};
            mem[3] = {OP_CMD, 8'h29};
         end
         2: begin
            for (int i = 0; i < 32; i++) mem[i] = {OP_CMD, 8'(i * 3 + 1)};
         end
         3: begin
            mem[0] = {OP_DATA, 8'h3C};
            mem[1] = {OP_DELAY, 8'd0};
            mem[2] = {OP_DELAY, 8'd0};
            mem[3] = {OP_CMD, 8'h2C};
            mem[4] = {OP_DATA, 8'h77};
         end
         default: begin
         end
      endcase
   endtask

   task automatic build_exp();
      logic [1:0] op;
      expq.delete();
      for (int i = 0; i < 32; i++) begin
         op = mem[i][9:8];
         if (op == OP_END) break;
         if (op == OP_CMD || op == OP_DATA) expq.push_back({op[0], mem[i][7:0]});
      end
   endtask

   task automatic go_pulse();
      @(negedge clk) go = 1'b1;
      @(negedge clk) go = 1'b0;
   endtask

   task automatic pulse_tick();
      @(negedge clk) tick_m = 1'b1;
      @(negedge clk) tick_m = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic wait_done(input int budget, input string nm);
      int k = 0;
      while (!seq_done && k < budget) begin
         @(negedge clk);
         k++;
      end
      chk(nm, seq_done, 1);
   endtask

   task automatic wait_start(input int target, input int budget, input string nm);
      int k = 0;
      while (n_start < target && k < budget) begin
         @(negedge clk);
         k++;
      end
      chk(nm, n_start, target);
   endtask

   task automatic wait_model_idle(input int budget);
      int k = 0;
      while ((m_busy || m_rise != 0) && k < budget) begin
         @(negedge clk);
         k++;
      end
      chk("model_idle", m_busy, 0);
   endtask

   task automatic chk_reset_vals(input string nm);
      chk(nm, {bus.cmd_addr, bus.spi_start, bus.spi_data, bus.spi_dc,
               lcd_rst_n, seq_busy, seq_done, seq_err},
          {5'd0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
   endtask

   initial begin
      int base;
      int k;
      int mism;
      int got;
      logic moved;

      vecs[0] = '{0, 2, 9'h011, 9'h1A5, 5'd2};
      vecs[1] = '{1, 2, 9'h001, 9'h029, 5'd4};
      vecs[2] = '{2, 32, 9'h001, 9'h05E, 5'd31};
      vecs[3] = '{3, 3, 9'h13C, 9'h177, 5'd5};
      vecs[4] = '{4, 0, 9'h000, 9'h000, 5'd0};

      load_prog(0);
      repeat (3) @(negedge clk);
      chk_reset_vals("reset_vals");
      @(negedge clk) rst = 1'b0;
      repeat (2) @(negedge clk);

      // Basic sequence with hand-placed ticks
      base = n_start;
      go_pulse();
      chk("b_rst_low", lcd_rst_n, 0);
      chk("b_busy_set", seq_busy, 1);
      pulse_tick();
      chk("b_rst_after1", lcd_rst_n, 0);
      pulse_tick();
      chk("b_rst_after2", lcd_rst_n, 1);
      pulse_tick();
      pulse_tick();
      repeat (6) @(negedge clk);
      chk("b_no_early_start", n_start - base, 0);
      pulse_tick();
      wait_start(base + 1, 12, "b_first_start");
      wait_done(200, "b_done");
      @(negedge clk);
      chk("b_nstart", n_start - base, 2);
      if (n_start - base == 2) begin
         chk("b_byte0", slog[base], 9'h011);
         chk("b_byte1", slog[base + 1], 9'h1A5);
      end
      chk("b_busy_clr", seq_busy, 0);

      // DELAY 5 waits five ticks; DELAY 0 costs two fetch/decode cycles
      wait_model_idle(50);
      load_prog(1);
      base = n_start;
      go_pulse();
      repeat (5) pulse_tick();
      wait_start(base + 1, 12, "c_first_start");
      k = 0;
      while (m_busy == 1'b0 && k < 20) begin
         @(negedge clk);
         k++;
      end
      k = 0;
      while (m_busy == 1'b1 && k < 20) begin
         @(negedge clk);
         k++;
      end
      repeat (6) @(negedge clk);
      repeat (4) pulse_tick();
      repeat (6) @(negedge clk);
      chk("c_hold_4ticks", n_start - base, 1);
      @(negedge clk) tick_m = 1'b1;
      k = 0;
      got = 0;
      while (k < 20 && got == 0) begin
         @(negedge clk);
         tick_m = 1'b0;
         k++;
         if (bus.spi_start) got = k;
      end
      chk("c_start_latency", got, 6);
      chk("c_second_byte", bus.spi_data, 8'h29);
      wait_done(200, "c_done");

      // spi_start withheld while busy; address holds until busy falls
      wait_model_idle(50);
      load_prog(0);
      force_busy = 1'b1;
      base = n_start;
      go_pulse();
      repeat (5) pulse_tick();
      repeat (20) @(negedge clk);
      chk("d_withheld", n_start - base, 0);
      force_busy = 1'b0;
      wait_start(base + 1, 4, "d_start_after_busy");
      moved = 1'b0;
      k = 0;
      while ((m_rise != 0 || m_busy) && k < 40) begin
         if (bus.cmd_addr != 5'd0) moved = 1'b1;
         @(negedge clk);
         k++;
      end
      chk("d_addr_held", moved, 0);
      repeat (4) @(negedge clk);
      chk("d_addr_adv", bus.cmd_addr, 5'd1);
      wait_done(200, "d_done");

      // Vector table, free-running ticks
      tick_auto = 1'b1;
      for (int v = 0; v < 5; v++) begin
         wait_model_idle(50);
         load_prog(vecs[v].prog);
         build_exp();
         base = n_start;
         go_pulse();
         wait_done(3000, "vec_done");
         @(negedge clk);
         chk("vec_nstart", n_start - base, vecs[v].exp_n);
         chk("vec_addr", bus.cmd_addr, vecs[v].exp_addr);
         chk("vec_busy", seq_busy, 0);
         chk("vec_lcd_rst_n", lcd_rst_n, 1);
         if (n_start - base == vecs[v].exp_n && vecs[v].exp_n > 0) begin
            chk("vec_first", slog[base], vecs[v].exp_first);
            chk("vec_last", slog[base + vecs[v].exp_n - 1], vecs[v].exp_last);
            mism = 0;
            for (int i = 0; i < expq.size(); i++)
               if (slog[base + i] != expq[i]) mism++;
            chk("vec_bytes", mism, 0);
         end
      end

      // go while busy ignored; async reset mid-XFER; fresh restart
      wait_model_idle(50);
      load_prog(3);
      base = n_start;
      go_pulse();
      k = 0;
      while (!lcd_rst_n && k < 100) begin
         @(negedge clk);
         k++;
      end
      go_pulse();
      @(negedge clk);
      chk("e_go_ignored", {lcd_rst_n, seq_busy}, 2'b11);
      k = 0;
      while (!(n_start - base == 2 && m_busy) && k < 400) begin
         @(negedge clk);
         k++;
      end
      @(negedge clk);
      #2 rst = 1'b1;
      #1 chk_reset_vals("e_async_reset");
      repeat (2) @(negedge clk);
      rst = 1'b0;
      wait_model_idle(50);
      chk("e_no_start_after_rst", n_start - base, 2);
      base = n_start;
      go_pulse();
      chk("e_restart", {bus.cmd_addr, lcd_rst_n}, {5'd0, 1'b0});
      wait_done(1000, "e_done");
      @(negedge clk);
      chk("e_nstart", n_start - base, 3);
      if (n_start - base == 3) chk("e_first", slog[base], 9'h13C);

      // SPI master never releases busy
      wait_model_idle(50);
      load_prog(0);
      m_hang = 1'b1;
      base = n_start;
      go_pulse();
      wait_start(base + 1, 200, "f_start");
      k = tick_cnt;
`ifdef LCD_SEQ_WATCHDOG_EN
      wait_done(300 * TPER + 100, "f_wd_done");
      chk("f_err", seq_err, 1);
      chk("f_busy", seq_busy, 0);
      chk("f_ticks_ok", (tick_cnt - k >= 255) && (tick_cnt - k <= 258), 1);
      chk("f_one_start", n_start - base, 1);
`else
      repeat (300 * TPER) @(negedge clk);
      chk("f_stuck_busy", seq_busy, 1);
      chk("f_no_err", seq_err, 0);
      chk("f_no_done", seq_done, 0);
      chk("f_one_start", n_start - base, 1);
`endif

      chk("data_stable", stab_bad, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
